// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a valid/ready load handshake and gap-free back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] din_i,
    output logic             sout_o,
    output logic             sout_valid_o,
    output logic             sout_last_o
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FL = WIDTH + 1;
`else
    localparam int unsigned FL = WIDTH;
`endif
    localparam int unsigned CW = $clog2(FL + 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             sout_last_q, sout_last_d;
    logic             last_bit;
    logic             accept;
    logic             first_bit;
    logic             next_bit;

    // cnt_q always indexes the bit currently driven on sout_o
    assign last_bit     = (state_q == StShift) && (cnt_q == CW'(FL - 1));
    assign load_ready_o = rst_ni && ((state_q == StIdle) || last_bit);
    assign accept       = load_valid_i && load_ready_o;
    assign first_bit    = LSB_FIRST ? din_i[0] : din_i[WIDTH-1];

`ifdef PISO_PARITY_EN
    logic parity_q, parity_d;

    assign next_bit = (cnt_q == CW'(WIDTH - 1)) ? parity_q
                    : (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]);

    always_comb begin
        parity_d = parity_q;
        if (accept) begin
            parity_d = ^din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`else
    assign next_bit = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        sout_last_d  = 1'b0;
        if (accept) begin
            state_d      = StShift;
            cnt_d        = '0;
            shreg_d      = LSB_FIRST ? (din_i >> 1) : (din_i << 1);
            sout_d       = first_bit;
            sout_valid_d = 1'b1;
        end else if (state_q == StShift) begin
            if (last_bit) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                cnt_d        = cnt_q + CW'(1);
                shreg_d      = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
                sout_d       = next_bit;
                sout_valid_d = 1'b1;
                sout_last_d  = (cnt_q == CW'(FL - 2));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            shreg_q      <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            sout_last_q  <= sout_last_d;
        end
    end

    assign sout_o       = sout_q;
    assign sout_valid_o = sout_valid_q;
    assign sout_last_o  = sout_last_q;

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out serializer that converts a WIDTH-bit word into a one-bit-per-clock stream. It is the stage directly upstream of the serial-in serial-out shift register and drives that register's serial data input `d`. A valid/ready load handshake accepts words. Back-to-back words stream with no idle cycle between frames.

## Interface
- `WIDTH`, default 4: data word width in bits, ≥ 2.
- `LSB_FIRST`, default 0: 0 sends din[WIDTH-1] first; 1 sends din[0] first.

- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `load_valid`  input  1  `din` holds a word to serialize.
- `load_ready`  output  1  the block accepts a word this cycle.
- `din`  input  WIDTH  parallel word; sampled only on an accepted load.
- `sout`  output  1  serial data bit; connects to the downstream `d`.
- `sout_valid`  output  1  `sout` carries a frame bit this cycle.
- `sout_last`  output  1  `sout` carries the final bit of the frame.

## Operation
- A load is accepted on a rising edge where `load_valid && load_ready`. `din` is captured into an internal shift register.
- FSM states:
  - IDLE: no frame in progress.
  - SHIFT: frame bits being emitted.
- FSM transitions:
  - IDLE → SHIFT on an accepted load.
  - SHIFT → SHIFT on the last bit when a new load is accepted in that same cycle.
  - SHIFT → IDLE on the last bit when no load is accepted.
- Frame length FL is WIDTH, or WIDTH+1 when parity is enabled.
- Bit counter:
  - Width is $clog2(FL+1).
  - Loads 0 on accept and increments once per emitted bit.
  - The last bit is count == FL-1.
  - The counter never wraps past FL-1.
- `load_ready` = rst && (state == IDLE || (state == SHIFT && last bit)). This is combinational from registered state.
- `load_valid` while `load_ready` = 0 is ignored: no capture and no disturbance to the current frame. The source must hold the word until accepted.
- `sout`, `sout_valid` and `sout_last` are registered outputs. `sout` is 0 whenever `sout_valid` = 0.
- Reset (rst low, any time, including mid-frame):
  - Immediately forces IDLE.
  - Clears counter and shift register.
  - `sout` = 0, `sout_valid` = 0, `sout_last` = 0.
  - `load_ready` = 0 while rst is low.
  - The partial frame is discarded and not resumed after reset release.
- Only a new accepted load starts a new frame after reset.

## Timing
- Load latency is 1 cycle: the edge that accepts the word launches bit 0 onto `sout`.
- Bit k of the frame is on `sout` during cycle k+1 after the accepting edge.
- `sout_valid` stays high for exactly FL consecutive cycles per frame.
- `sout_last` is high only in the cycle carrying bit FL-1.
- Back-to-back: a load accepted on the edge ending the last-bit cycle puts the next frame's bit 0 on `sout` in the following cycle. `sout_valid` then stays high continuously, with no gap.
- Throughput is 1 bit per clock. The minimum load spacing is FL cycles.
- In the first cycle after rst deasserts, `load_ready` = 1 and outputs still hold their reset values.

## Configuration
- `PISO_PARITY_EN` defined: one even-parity bit is appended after the data bits.
  - The parity bit is ^din of the captured word.
  - FL = WIDTH+1, and `sout_last` marks the parity bit.
- `PISO_PARITY_EN` undefined: no parity logic is built and FL = WIDTH.

## Test plan
- **Reset:** hold rst = 0 for 2 cycles with `load_valid` = 1.
  - Required: `sout`, `sout_valid` and `sout_last` = 0 and `load_ready` = 0 throughout.
  - Required: nothing is captured.
- **MSB-first:** WIDTH = 4, LSB_FIRST = 0, load 4'b1101.
  - Required: `sout` = 1,1,0,1 in cycles 1–4 after accept.
  - Required: `sout_valid` high for exactly 4 cycles, `sout_last` high in cycle 4 only, `load_ready` high again in cycle 4.
- **LSB-first and back-to-back:** LSB_FIRST = 1, load 4'b1101, then 4'b0110 accepted in the last-bit cycle.
  - Required: `sout` = 1,0,1,1,0,1,1,0 with `sout_valid` high for 8 consecutive cycles.
  - Required: `sout_last` high in cycles 4 and 8.
- **Stall:** hold `load_valid` = 1 with 4'b0011 during an active frame of 4'b1101.
  - Required: the 1101 frame is unchanged.
  - Required: 0011 is accepted only in the last-bit cycle and follows immediately.
- **Reset mid-frame:** assert rst low after bit 1 of 4'b1101.
  - Required: outputs go to 0 asynchronously, before the next clock edge.
  - Required: after release, `sout_valid` stays 0 until a new load.
- **Parity** (`PISO_PARITY_EN`), load 4'b1101:
  - Required: `sout` = 1,1,0,1,1, with the fifth bit being parity.
  - Required: `sout_last` on the fifth bit.
  - Loading 4'b1001 gives parity bit 0.
